// File: rtl/histogram_if.sv
// Pixel/histogram bus: the master drives clear, increment and gray level;
// the slave answers with the registered gray level and its bin count.
interface histogram_if #(
  parameter int CW = 20
);
  logic          iClear;
  logic          iInc;
  logic [7:0]    iGray;
  logic [7:0]    oGray;
  logic [CW-1:0] oGrayHisto;

  modport master (
    output iClear, iInc, iGray,
    input  oGray, oGrayHisto
  );

  modport slave (
    input  iClear, iInc, iGray,
    output oGray, oGrayHisto
  );
endinterface

// File: rtl/histogram.sv
// 256-bin gray-level histogram with a read-modify-write increment pipeline,
// write-to-read forwarding, saturating counters and a sweeping clear.
module histogram #(
  parameter int BINS = 256,
  parameter int CW   = 20
) (
  input  logic        iClk,
  input  logic        iRst_n,
  histogram_if.slave  bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] mem [BINS];

  logic [CW-1:0] rd_q;
  logic [CW-1:0] fwd_data_q, fwd_data_d;
  logic          fwd_v_q, fwd_v_d;
  logic [7:0]    gray_q, gray_d;
  logic [7:0]    ptr_q, ptr_d;
  logic          inc_v_q, inc_v_d;
  logic          zero_q, zero_d;

  logic          wr_en;
  logic [7:0]    wr_addr;
  logic [CW-1:0] wr_data;
  logic [CW-1:0] base;
  logic [CW-1:0] inc_data;

  // Current count of bin gray_q, write port arbitration and next-state terms.
  // base already includes every increment sampled before the last edge,
  // because a write that landed on the same edge as the read is forwarded.
  always_comb begin
    base     = fwd_v_q ? fwd_data_q : rd_q;
    inc_data = (base == CNT_MAX) ? base : base + 1'b1;

    wr_en   = 1'b0;
    wr_addr = gray_q;
    wr_data = inc_data;
    if (bus.iClear) begin
      // Clear owns the write port; an in-flight increment is discarded.
      wr_en   = 1'b1;
      wr_addr = ptr_q;
      wr_data = '0;
    end else if (inc_v_q) begin
      wr_en = 1'b1;
    end

    gray_d     = bus.iGray;
    inc_v_d    = bus.iInc & ~bus.iClear;
    zero_d     = bus.iClear;
    // Pointer only advances while clearing, so every clear starts at bin 0.
    ptr_d      = bus.iClear ? ptr_q + 8'd1 : 8'd0;
    fwd_v_d    = wr_en && (wr_addr == bus.iGray);
    fwd_data_d = wr_data;
  end

  // Bin storage: single write port, registered read of the requested bin.
  always_ff @(posedge iClk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= mem[bus.iGray];
  end

  // Forwarded write data travels alongside the RAM read data.
  always_ff @(posedge iClk) begin
    fwd_data_q <= fwd_data_d;
  end

  // Control state; reset drops any pending write and blanks the outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      gray_q  <= 8'd0;
      ptr_q   <= 8'd0;
      inc_v_q <= 1'b0;
      zero_q  <= 1'b1;
      fwd_v_q <= 1'b0;
    end else begin
      gray_q  <= gray_d;
      ptr_q   <= ptr_d;
      inc_v_q <= inc_v_d;
      zero_q  <= zero_d;
      fwd_v_q <= fwd_v_d;
    end
  end

  assign bus.oGray      = gray_q;
  assign bus.oGrayHisto = zero_q ? '0 : base;

endmodule

// File: tb/tb_histogram.sv
// Scoreboard bench for histogram: a per-bin reference model produces the
// expected (gray, count) pair for every scored cycle.
module tb_histogram;

  localparam int CW   = 12;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  histogram_if #(.CW(CW)) bus ();

  histogram #(.BINS(256), .CW(CW)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] g;
    int         h;
  } exp_t;

  exp_t  sb[$];
  int    model [256];
  int    ptr_m;
  bit    pend_v;
  int    pend_a;
  int    pend_old;
  int    n_cmp = 0;
  int    n_err = 0;
  int    rd_sum;
  string phase;

  task automatic check_eq(string tag, int obs, int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, push expectation, advance reference, compare.
  task automatic step(bit clr, bit inc, logic [7:0] g, bit chk);
    exp_t e;
    bus.iClear = clr;
    bus.iInc   = inc;
    bus.iGray  = g;
    e.g = g;
    e.h = clr ? 0 : model[g];
    if (chk) sb.push_back(e);
    if (clr) begin
      if (pend_v) model[pend_a] = pend_old;
      pend_v = 1'b0;
      model[ptr_m] = 0;
      ptr_m = (ptr_m + 1) % 256;
    end else begin
      ptr_m = 0;
      if (inc) begin
        pend_old = model[g];
        pend_a   = g;
        pend_v   = 1'b1;
        model[g] = (model[g] == MAXC) ? MAXC : model[g] + 1;
      end else begin
        pend_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (chk) begin
      e = sb.pop_front();
      check_eq("gray", int'(bus.oGray), int'(e.g));
      check_eq("histo", int'(bus.oGrayHisto), e.h);
      rd_sum += int'(bus.oGrayHisto);
    end
  endtask

  task automatic read_all();
    int exp_sum;
    exp_sum = 0;
    for (int i = 0; i < 256; i++) exp_sum += model[i];
    rd_sum = 0;
    for (int i = 0; i < 256; i++) step(1'b0, 1'b0, 8'(i), 1'b1);
    check_eq("sum", rd_sum, exp_sum);
  endtask

  task automatic clear_all(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
  endtask

  initial begin
    logic [7:0] g;
    bus.iClear = 1'b0;
    bus.iInc   = 1'b0;
    bus.iGray  = 8'd0;
    for (int i = 0; i < 256; i++) model[i] = 0;
    ptr_m  = 0;
    pend_v = 1'b0;
    rd_sum = 0;

    phase = "reset";
    rst_n = 1'b0;
    #2;
    check_eq("gray", int'(bus.oGray), 0);
    check_eq("histo", int'(bus.oGrayHisto), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("phase reset: outputs idle");

    phase = "clear";
    clear_all(300);
    read_all();
    $display("phase clear: all bins read back");

    phase = "stream";
    g = 8'd0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 3) != 0) g = 8'($urandom_range(0, 255));
      step(1'b0, 1'b1, g, 1'b1);
    end
    step(1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    read_all();
    check_eq("total", rd_sum, 20000);
    $display("phase stream: 20000 pixels counted");

    phase = "burst";
    clear_all(256);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, 8'h55, 1'b1);
    step(1'b0, 1'b0, 8'h55, 1'b1);
    check_eq("bin55", int'(bus.oGrayHisto), 1000);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 8'h10 : 8'h11, 1'b1);
    step(1'b0, 1'b0, 8'h10, 1'b1);
    check_eq("bin10", int'(bus.oGrayHisto), 500);
    step(1'b0, 1'b0, 8'h11, 1'b1);
    check_eq("bin11", int'(bus.oGrayHisto), 500);
    $display("phase burst: same-bin and alternating bursts");

    phase = "saturate";
    for (int i = 0; i < MAXC - 1; i++) step(1'b0, 1'b1, 8'd7, 1'b0);
    step(1'b0, 1'b0, 8'd7, 1'b1);
    check_eq("bin7_pre", int'(bus.oGrayHisto), MAXC - 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd7, 1'b1);
    step(1'b0, 1'b0, 8'd7, 1'b1);
    check_eq("bin7_sat", int'(bus.oGrayHisto), MAXC);
    $display("phase saturate: bin 7 held at max");

    phase = "clr_prio";
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'd3, 1'b1);
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 8'd3, 1'b1);
    step(1'b0, 1'b0, 8'd3, 1'b1);
    check_eq("bin3", int'(bus.oGrayHisto), 0);
    $display("phase clr_prio: clear beat increment");

    phase = "inflight";
    clear_all(256);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'd200, 1'b1);
    step(1'b1, 1'b0, 8'd200, 1'b1);
    step(1'b0, 1'b0, 8'd200, 1'b1);
    check_eq("bin200", int'(bus.oGrayHisto), 4);
    $display("phase inflight: pending increment dropped on clear");

    phase = "async_rst";
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
    rst_n = 1'b0;
    if (pend_v) model[pend_a] = pend_old;
    pend_v = 1'b0;
    ptr_m  = 0;
    #1;
    check_eq("gray0", int'(bus.oGray), 0);
    check_eq("histo0", int'(bus.oGrayHisto), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    read_all();
    $display("phase async_rst: counts intact after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
